// File: rtl/ahb_lite_arbiter.sv
// Two-requester round-robin front end driving single, non-pipelined AHB-Lite transfers.
// Handles lane replication/extraction, alignment checks, wait states and ERROR responses.
module ahb_lite_arbiter #(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic        req0_write_i,
    input  logic [31:0] req0_addr_i,
    input  logic [2:0]  req0_size_i,
    input  logic [31:0] req0_wdata_i,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic        req1_write_i,
    input  logic [31:0] req1_addr_i,
    input  logic [2:0]  req1_size_i,
    input  logic [31:0] req1_wdata_i,

    output logic        resp0_valid_o,
    output logic [31:0] resp0_rdata_o,
    output logic        resp0_err_o,

    output logic        resp1_valid_o,
    output logic [31:0] resp1_rdata_o,
    output logic        resp1_err_o,

    output logic [31:0] ahb_haddr_o,
    output logic        ahb_hwrite_o,
    output logic [2:0]  ahb_hsize_o,
    output logic [2:0]  ahb_hburst_o,
    output logic [3:0]  ahb_hprot_o,
    output logic [1:0]  ahb_htrans_o,
    output logic        ahb_hmastlock_o,
    output logic [31:0] ahb_hwdata_o,
    input  logic        ahb_hready_i,
    input  logic        ahb_hresp_i,
    input  logic [31:0] ahb_hrdata_i
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t      state, state_nxt;
    logic        last_grant, owner;
    logic        grant_vld, grant_id, accept;
    logic        sel_write, sel_legal;
    logic [31:0] sel_addr, sel_wdata;
    logic [2:0]  sel_size;

    logic        write_q;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  size_q;

    logic        resp_load, load_id, resp_err_nxt;
    logic [31:0] resp_rdata_nxt;
    logic [31:0] rdata0_q, rdata1_q;
    logic        err0_q, err1_q;

    function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lsb);
        case (size)
            3'd0:    return 1'b1;
            3'd1:    return ~addr_lsb[0];
            3'd2:    return addr_lsb == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [31:0] data, input logic [2:0] size);
        case (size)
            3'd0:    return {4{data[7:0]}};
            3'd1:    return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] data, input logic [2:0] size,
                                                 input logic [1:0] addr_lsb);
        logic [31:0] r;
        r = data;
        case (size)
            3'd0: begin
                case (addr_lsb)
                    2'd0:    r = {24'd0, data[7:0]};
                    2'd1:    r = {24'd0, data[15:8]};
                    2'd2:    r = {24'd0, data[23:16]};
                    default: r = {24'd0, data[31:24]};
                endcase
            end
            3'd1:    r = addr_lsb[1] ? {16'd0, data[31:16]} : {16'd0, data[15:0]};
            default: r = data;
        endcase
        return r;
    endfunction

    // Grant: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant_vld = req0_valid_i | req1_valid_i;
        grant_id  = (req0_valid_i && req1_valid_i) ? ~last_grant : req1_valid_i;
        sel_write = grant_id ? req1_write_i : req0_write_i;
        sel_addr  = grant_id ? req1_addr_i  : req0_addr_i;
        sel_size  = grant_id ? req1_size_i  : req0_size_i;
        sel_wdata = grant_id ? req1_wdata_i : req0_wdata_i;
        sel_legal = cmd_legal(sel_size, sel_addr[1:0]);
        accept    = (state == ST_IDLE) && grant_vld;
    end

    assign req0_ready_o = accept && !grant_id;
    assign req1_ready_o = accept &&  grant_id;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = sel_legal ? ST_ADDR : ST_RESP;
            ST_ADDR: if (ahb_hready_i) state_nxt = ST_DATA;
            ST_DATA: if (ahb_hready_i) state_nxt = ST_RESP;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Response capture: illegal commands complete straight from IDLE, bus transfers on the last data cycle.
    always_comb begin
        load_id        = (state == ST_IDLE) ? grant_id : owner;
        resp_load      = (accept && !sel_legal) || (state == ST_DATA && ahb_hready_i);
        resp_err_nxt   = (state == ST_DATA) ? ahb_hresp_i : 1'b1;
        resp_rdata_nxt = '0;
        if (state == ST_DATA && !write_q && !ahb_hresp_i)
            resp_rdata_nxt = lane_extract(ahb_hrdata_i, size_q, addr_q[1:0]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner      <= grant_id;
                last_grant <= grant_id;
                write_q    <= sel_write;
                addr_q     <= sel_addr;
                size_q     <= sel_size;
                wdata_q    <= sel_wdata;
            end
            if (resp_load) begin
                if (load_id) begin
                    rdata1_q <= resp_rdata_nxt;
                    err1_q   <= resp_err_nxt;
                end else begin
                    rdata0_q <= resp_rdata_nxt;
                    err0_q   <= resp_err_nxt;
                end
            end
        end
    end

    always_comb begin
        ahb_htrans_o = HTRANS_IDLE;
        ahb_hwrite_o = 1'b0;
        ahb_hsize_o  = 3'd0;
        ahb_hwdata_o = '0;
        case (state)
            ST_ADDR: begin
                ahb_htrans_o = HTRANS_NONSEQ;
                ahb_hwrite_o = write_q;
                ahb_hsize_o  = size_q;
            end
            ST_DATA: ahb_hwdata_o = lane_replicate(wdata_q, size_q);
            default: ;
        endcase
    end

    assign ahb_haddr_o     = addr_q;
    assign ahb_hburst_o    = 3'b000;
    assign ahb_hprot_o     = HPROT_VAL;
    assign ahb_hmastlock_o = 1'b0;

    assign resp0_valid_o = (state == ST_RESP) && !owner;
    assign resp1_valid_o = (state == ST_RESP) &&  owner;
    assign resp0_rdata_o = rdata0_q;
    assign resp1_rdata_o = rdata1_q;
    assign resp0_err_o   = err0_q;
    assign resp1_err_o   = err1_q;

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// Bench for ahb_lite_arbiter: directed vector table, hand sequences and a randomized run
// scored against a transaction-level model, with a behavioural AHB slave.
module tb_ahb_lite_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  rv  = 2'b00;
    logic [1:0]  rw  = 2'b00;
    logic [31:0] ra  [2];
    logic [2:0]  rs  [2];
    logic [31:0] rwd [2];

    wire         rdy0, rdy1, rsv0, rsv1, rse0, rse1;
    wire  [31:0] rsd0, rsd1;
    wire  [31:0] haddr, hwdata;
    wire         hwrite, hmastlock;
    wire  [2:0]  hsize, hburst;
    wire  [3:0]  hprot;
    wire  [1:0]  htrans;
    logic        hready = 1'b1;
    logic        hresp  = 1'b0;
    logic [31:0] hrdata = '0;

    always #5 clk = ~clk;

    ahb_lite_arbiter #(.HPROT_VAL(4'b0011)) dut (
        .clk(clk), .reset(rst),
        .req0_valid_i(rv[0]), .req0_ready_o(rdy0), .req0_write_i(rw[0]),
        .req0_addr_i(ra[0]), .req0_size_i(rs[0]), .req0_wdata_i(rwd[0]),
        .req1_valid_i(rv[1]), .req1_ready_o(rdy1), .req1_write_i(rw[1]),
        .req1_addr_i(ra[1]), .req1_size_i(rs[1]), .req1_wdata_i(rwd[1]),
        .resp0_valid_o(rsv0), .resp0_rdata_o(rsd0), .resp0_err_o(rse0),
        .resp1_valid_o(rsv1), .resp1_rdata_o(rsd1), .resp1_err_o(rse1),
        .ahb_haddr_o(haddr), .ahb_hwrite_o(hwrite), .ahb_hsize_o(hsize),
        .ahb_hburst_o(hburst), .ahb_hprot_o(hprot), .ahb_htrans_o(htrans),
        .ahb_hmastlock_o(hmastlock), .ahb_hwdata_o(hwdata),
        .ahb_hready_i(hready), .ahb_hresp_i(hresp), .ahb_hrdata_i(hrdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Behavioural slave: accepts a NONSEQ, then inserts slv_waits low-hready cycles;
    // an error holds hresp high on the last wait cycle and the completing cycle.
    int          slv_waits = 0;
    bit          slv_err   = 1'b0;
    logic [31:0] slv_rdata = '0;
    int          nonseq_cnt = 0;
    logic [31:0] obs_addr = '0, obs_hwdata = '0;
    logic        obs_write = 1'b0;
    logic [2:0]  obs_size = '0;

    initial begin
        bit pend, dp;
        int left;
        pend = 0; dp = 0; left = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0; dp = 0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
            end else begin
                if (pend) begin
                    dp = 1; left = slv_waits; obs_hwdata = hwdata;
                end else if (!(dp && !hready)) begin
                    dp = 0;
                end
                if (dp) begin
                    if (left > 0) begin
                        hready = 1'b0;
                        hresp  = slv_err && (left == 1);
                        hrdata = ~slv_rdata;
                        left--;
                    end else begin
                        hready = 1'b1; hresp = slv_err; hrdata = slv_rdata;
                    end
                end else begin
                    hready = 1'b1; hresp = 1'b0;
                end
                pend = (htrans == 2'b10) && hready;
                if (pend) begin
                    nonseq_cnt++;
                    obs_addr = haddr; obs_write = hwrite; obs_size = hsize;
                end
            end
        end
    end

    // Transaction-level reference model.
    bit          m_last = 1'b1;
    logic [31:0] m_rd  [2] = '{32'd0, 32'd0};
    bit          m_err [2] = '{1'b0, 1'b0};

    function automatic bit m_legal(input logic [31:0] a, input logic [2:0] s);
        if (s > 3'd2) return 1'b0;
        return (int'(a[1:0]) % (1 << int'(s))) == 0;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        longint v, mask;
        v    = longint'({32'd0, d}) >> (8 * int'(a[1:0]));
        mask = (64'sd1 <<< (8 << int'(s))) - 1;
        return 32'(v & mask);
    endfunction

    function automatic logic [31:0] m_hwdata(input logic [31:0] wd, input logic [2:0] s);
        logic [31:0] r;
        int nb;
        nb = 1 << int'(s);
        for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % nb) +: 8];
        return r;
    endfunction

    function automatic logic rsp_v(input int i);
        return (i != 0) ? rsv1 : rsv0;
    endfunction
    function automatic logic [31:0] rsp_rd(input int i);
        return (i != 0) ? rsd1 : rsd0;
    endfunction
    function automatic logic rsp_err(input int i);
        return (i != 0) ? rse1 : rse0;
    endfunction

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  sz;
        logic [31:0] wd;
    } cmd_t;

    task automatic run_txn(input bit v0, input bit v1, input cmd_t c0, input cmd_t c1,
                           input int waits, input bit serr, input logic [31:0] srd,
                           input logic [31:0] exp_rd, input bit exp_err, input int exp_lat,
                           input string tag);
        int   w, o, lat, g, ns0;
        bit   busy_rdy;
        cmd_t cw;
        w  = (v0 && v1) ? (m_last ? 0 : 1) : (v1 ? 1 : 0);
        o  = 1 - w;
        cw = (w != 0) ? c1 : c0;
        slv_waits = waits; slv_err = serr; slv_rdata = srd;
        ns0 = nonseq_cnt;
        @(negedge clk);
        rv = {v1, v0};
        rw[0] = c0.wr; ra[0] = c0.addr; rs[0] = c0.sz; rwd[0] = c0.wd;
        rw[1] = c1.wr; ra[1] = c1.addr; rs[1] = c1.sz; rwd[1] = c1.wd;
        #1;
        g = 0;
        while ({rdy1, rdy0} == 2'b00 && g < 40) begin
            @(negedge clk); #1; g++;
        end
        if ({rdy1, rdy0} == 2'b00) begin
            fail_timeout({tag, " ready"});
            rv = 2'b00;
            return;
        end
        check({tag, " grant"}, 32'({rdy1, rdy0}), (w != 0) ? 32'd2 : 32'd1);
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        rv[w] = 1'b0;
        rw[w] = 1'($urandom); ra[w] = $urandom; rs[w] = 3'($urandom); rwd[w] = $urandom;
        #1;
        busy_rdy = 1'b0;
        while (!rsp_v(w) && lat < 40) begin
            busy_rdy |= rdy0 | rdy1;
            @(negedge clk);
            lat++;
        end
        if (!rsp_v(w)) begin
            fail_timeout({tag, " resp"});
            rv = 2'b00;
            return;
        end
        busy_rdy |= rdy0 | rdy1;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, rsp_rd(w), exp_rd);
        check({tag, " err"}, 32'(rsp_err(w)), 32'(exp_err));
        check({tag, " other_valid"}, 32'(rsp_v(o)), 32'd0);
        check({tag, " other_rdata"}, rsp_rd(o), m_rd[o]);
        check({tag, " other_err"}, 32'(rsp_err(o)), 32'(m_err[o]));
        check({tag, " ready_busy"}, 32'(busy_rdy), 32'd0);
        check({tag, " nonseq"}, 32'(nonseq_cnt - ns0), m_legal(cw.addr, cw.sz) ? 32'd1 : 32'd0);
        if (m_legal(cw.addr, cw.sz)) begin
            check({tag, " haddr"}, obs_addr, cw.addr);
            check({tag, " hwrite"}, 32'(obs_write), 32'(cw.wr));
            check({tag, " hsize"}, 32'(obs_size), 32'(cw.sz));
            if (cw.wr) check({tag, " hwdata"}, obs_hwdata, m_hwdata(cw.wd, cw.sz));
        end
        m_rd[w] = exp_rd; m_err[w] = exp_err; m_last = w[0];
        rv = 2'b00;
    endtask

    typedef struct {
        bit          id;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  sz;
        logic [31:0] wd;
        int          waits;
        bit          serr;
        logic [31:0] srd;
        logic [31:0] erd;
        bit          eerr;
        int          elat;
    } vec_t;

    vec_t tbl[10];

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        rv  = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1;
        m_rd[0] = '0; m_rd[1] = '0; m_err[0] = 1'b0; m_err[1] = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t c, c0, c1, nul;
        int   acc, waits;
        bit   serr, v0, v1, w;
        logic [1:0] cur, prev;
        logic [31:0] srd, erd;
        bit   eerr;
        int   elat;

        //         id  wr  addr           sz  wdata          wt err srd            exp_rd         eerr lat
        tbl[0] = '{0, 1, 32'h8000_2000, 2, 32'h0000_00A5, 0, 0, 32'h0,         32'h0,         0, 3};
        tbl[1] = '{0, 0, 32'h8000_2003, 0, 32'h0,         2, 0, 32'h1122_3344, 32'h0000_0011, 0, 5};
        tbl[2] = '{0, 0, 32'h8000_2000, 2, 32'h0,         1, 1, 32'hDEAD_BEEF, 32'h0,         1, 4};
        tbl[3] = '{1, 0, 32'h8000_2002, 1, 32'h0,         0, 0, 32'h1122_3344, 32'h0000_1122, 0, 3};
        tbl[4] = '{1, 1, 32'h8000_0002, 2, 32'h5555_5555, 0, 0, 32'h0,         32'h0,         1, 1};
        tbl[5] = '{1, 0, 32'h0000_0000, 3, 32'h0,         0, 0, 32'h0,         32'h0,         1, 1};
        tbl[6] = '{0, 1, 32'h0000_0001, 1, 32'h0000_1234, 0, 0, 32'h0,         32'h0,         1, 1};
        tbl[7] = '{1, 1, 32'h4000_0001, 0, 32'h1234_56C3, 1, 0, 32'h0,         32'h0,         0, 4};
        tbl[8] = '{0, 0, 32'h0000_0010, 1, 32'h0,         0, 0, 32'hCAFE_F00D, 32'h0000_F00D, 0, 3};
        tbl[9] = '{1, 1, 32'h0000_0004, 1, 32'h0000_BEEF, 2, 1, 32'h0,         32'h0,         1, 5};

        ra[0] = '0; ra[1] = '0; rs[0] = '0; rs[1] = '0; rwd[0] = '0; rwd[1] = '0;
        nul = '{0, 32'h0, 3'd0, 32'h0};

        // Reset state, sampled while reset is still asserted.
        repeat (2) @(negedge clk);
        #1;
        check("rst htrans", 32'(htrans), 32'd0);
        check("rst haddr", haddr, 32'd0);
        check("rst hwrite", 32'(hwrite), 32'd0);
        check("rst hwdata", hwdata, 32'd0);
        check("rst hprot", 32'(hprot), 32'h3);
        check("rst hburst_lock", 32'({hburst, hmastlock}), 32'd0);
        check("rst resp_valid", 32'({rsv1, rsv0}), 32'd0);
        check("rst rdata", rsd0 | rsd1, 32'd0);
        apply_reset();

        // Both requesters held valid from reset: grants alternate 0,1,0,1 with one-cycle ready pulses.
        @(negedge clk);
        rw[0] = 1'b1; ra[0] = 32'h0000_0100; rs[0] = 3'd2; rwd[0] = 32'h0101_0101;
        rw[1] = 1'b1; ra[1] = 32'h0000_0200; rs[1] = 3'd2; rwd[1] = 32'h0202_0202;
        slv_waits = 0; slv_err = 1'b0;
        rv = 2'b11;
        acc = 0; prev = 2'b00;
        for (int cyc = 0; cyc < 100 && acc < 4; cyc++) begin
            #1;
            cur = {rdy1, rdy0};
            if (prev != 2'b00) check("rr ready_pulse", 32'(cur), 32'd0);
            if (cur != 2'b00) begin
                check("rr order", 32'(cur), (acc % 2 != 0) ? 32'd2 : 32'd1);
                acc++;
            end
            prev = cur;
            if (acc < 4) @(negedge clk);
        end
        if (acc < 4) fail_timeout("rr accepts");
        @(negedge clk); #1;
        check("rr last_pulse", 32'({rdy1, rdy0}), 32'd0);
        rv = 2'b00;
        repeat (8) @(negedge clk);
        m_last = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            c = '{tbl[i].wr, tbl[i].addr, tbl[i].sz, tbl[i].wd};
            run_txn(!tbl[i].id, tbl[i].id, c, c, tbl[i].waits, tbl[i].serr, tbl[i].srd,
                    tbl[i].erd, tbl[i].eerr, tbl[i].elat, $sformatf("vec%0d", i));
        end

        // Randomized commands, single and contending requesters.
        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom); v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            for (int k = 0; k < 2; k++) begin
                c.wr = 1'($urandom);
                c.sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                c.addr = $urandom;
                c.wd = $urandom;
                if (c.sz <= 3'd2 && $urandom_range(0, 3) != 0)
                    c.addr = c.addr & ~((32'd1 << c.sz) - 32'd1);
                if (k == 0) c0 = c; else c1 = c;
            end
            waits = $urandom_range(0, 3);
            serr = ($urandom_range(0, 4) == 0);
            if (serr && waits == 0) waits = 1;
            srd = $urandom;
            w = (v0 && v1) ? !m_last : v1;
            c = w ? c1 : c0;
            if (!m_legal(c.addr, c.sz)) begin
                erd = '0; eerr = 1'b1; elat = 1;
            end else begin
                eerr = serr;
                erd  = (!c.wr && !serr) ? m_rdata(c.addr, c.sz, srd) : 32'd0;
                elat = 3 + waits;
            end
            run_txn(v0, v1, c0, c1, waits, serr, srd, erd, eerr, elat, $sformatf("rnd%0d", i));
        end

        // Reset while stalled in the data phase: outputs clear at once, transfer is dropped.
        slv_waits = 5; slv_err = 1'b0; slv_rdata = 32'h7777_7777;
        @(negedge clk);
        rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 32'h0000_0020; rs[1] = 3'd2;
        #1;
        acc = 0;
        while (!rdy1 && acc < 20) begin
            @(negedge clk); #1; acc++;
        end
        if (!rdy1) fail_timeout("midrst ready");
        @(posedge clk);
        @(negedge clk);
        rv = 2'b00;
        @(negedge clk);
        check("midrst stalled", 32'(hready), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst htrans", 32'(htrans), 32'd0);
        check("midrst haddr", haddr, 32'd0);
        check("midrst resp_valid", 32'({rsv1, rsv0}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1;
        m_rd[0] = '0; m_rd[1] = '0; m_err[0] = 1'b0; m_err[1] = 1'b0;
        c0 = '{0, 32'h0000_0040, 3'd2, 32'h0};
        c1 = '{1, 32'h0000_0044, 3'd2, 32'h0BAD_0BAD};
        run_txn(1'b1, 1'b1, c0, c1, 0, 1'b0, 32'h89AB_CDEF, 32'h89AB_CDEF, 1'b0, 3, "post_rst");
        c0 = nul;
        run_txn(1'b1, 1'b1, c0, c1, 0, 1'b0, 32'h0, 32'h0, 1'b0, 3, "post_rst2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
